// File: rtl/rf_pkg.sv
// Shared constants, the buffered writeback record and the round-robin helper
// for the register-file write arbiter.
package rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;
  localparam int CNT_W  = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // The pointer only moves when both requesters competed; it then favours the loser.
  function automatic logic rr_next(input logic rr, input logic contended);
    return contended ? ~rr : rr;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus between decode / writeback requesters and the write arbiter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; ready is combinational and valid must not depend on ready.
interface rf_write_arbiter_if;
  import rf_pkg::*;

  logic                  rsv_valid;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  rsv_ready;
  logic [1:0]            wb_valid;
  logic [2*ADDR_W-1:0]   wb_addr;
  logic [2*DATA_W-1:0]   wb_data;
  logic [1:0]            wb_ready;
  logic                  rf_we;
  logic [ADDR_W-1:0]     rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [NREGS-1:0]      busy;
  logic                  err_underflow;

  modport master (
    output rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data,
    input  rsv_ready, wb_ready, rf_we, rf_waddr, rf_wdata, busy, err_underflow
  );

  modport slave (
    input  rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data,
    output rsv_ready, wb_ready, rf_we, rf_waddr, rf_wdata, busy, err_underflow
  );

endinterface

// File: rtl/rf_pend_counter.sv
// Pending-write counter for one architectural register: counts reservations not
// yet committed, saturates at CNT_MAX, and latches a sticky underflow flag when
// a commit arrives with nothing pending.
module rf_pend_counter
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             uflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uflow_q, uflow_d;

  // Next count: simultaneous reserve and commit cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    uflow_d = uflow_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             uflow_d = 1'b1;
    end
  end

  // Count and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign busy_o  = (cnt_q != '0);
  assign uflow_o = uflow_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the execute (req0) and
// memory (req1) writebacks, and keeps the per-register pending-write scoreboard.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rf_write_arbiter_if.slave bus
);

  logic [1:0]        full_q, full_d;
  wb_req_t           buf_q [2];
  wb_req_t           buf_d [2];
  logic              rr_q, rr_d;
  logic [1:0]        grant;
  logic              gnt_any;
  wb_req_t           gnt_req;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [NREGS-1:0]  inc, dec, busy_w, uflow_w;
  logic [CNT_W-1:0]  cnt [NREGS];

  // One grant per cycle; the rr pointer only breaks ties.
  always_comb begin
    grant = '0;
    if (&full_q) grant[rr_q] = 1'b1;
    else         grant       = full_q;
    gnt_any = |grant;
    gnt_req = buf_q[grant[1]];
  end

  // A buffer granted this cycle frees in time to accept a new writeback.
  assign bus.wb_ready  = ~full_q | grant;
  // At saturation a reservation is only taken if a commit to the same register frees a slot.
  assign bus.rsv_ready = !((cnt[bus.rsv_addr] == CNT_MAX) && !dec[bus.rsv_addr]);

  // Holding buffer and pointer next state.
  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    rr_d   = rr_next(rr_q, &full_q);
    for (int i = 0; i < 2; i++) begin
      if (bus.wb_valid[i] && bus.wb_ready[i]) begin
        full_d[i]     = 1'b1;
        buf_d[i].addr = bus.wb_addr[i*ADDR_W +: ADDR_W];
        buf_d[i].data = bus.wb_data[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  // Buffers, pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      rr_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      full_q  <= full_d;
      buf_q   <= buf_d;
      rr_q    <= rr_d;
      rf_we_q <= gnt_any;
      if (gnt_any) begin
        rf_waddr_q <= gnt_req.addr;
        rf_wdata_q <= gnt_req.data;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    assign inc[g] = bus.rsv_valid && bus.rsv_ready && (bus.rsv_addr == ADDR_W'(g));
    assign dec[g] = gnt_any && (gnt_req.addr == ADDR_W'(g));

    rf_pend_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc[g]),
      .dec_i   (dec[g]),
      .cnt_o   (cnt[g]),
      .busy_o  (busy_w[g]),
      .uflow_o (uflow_w[g])
    );
  end

  assign bus.rf_we         = rf_we_q;
  assign bus.rf_waddr      = rf_waddr_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.busy          = busy_w;
  assign bus.err_underflow = |uflow_w;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of buffers, arbitration
// and per-register pending counts.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural model state
  int          cnt_m [NREGS];
  bit          full_m [2];
  logic [3:0]  addr_m [2];
  logic [15:0] data_m [2];
  bit          rr_m;
  bit          we_m;
  logic [3:0]  waddr_m;
  logic [15:0] wdata_m;
  bit          err_m;
  logic [19:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) cnt_m[r] = 0;
    full_m[0] = 0; full_m[1] = 0;
    rr_m = 0; we_m = 0; waddr_m = '0; wdata_m = '0; err_m = 0;
    exp_q.delete();
  endtask

  // Who the model says is granted this cycle.
  task automatic model_grant(output bit gv, output int g);
    gv = full_m[0] || full_m[1];
    if (full_m[0] && full_m[1]) g = rr_m ? 1 : 0;
    else                        g = full_m[0] ? 0 : 1;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    bit gv; int g; bit rdy [2]; bit rsv_ok; bit inc;
    logic [3:0] ra, ga;
    model_grant(gv, g);
    ga = addr_m[g];
    ra = bus.rsv_addr;
    for (int i = 0; i < 2; i++) rdy[i] = !full_m[i] || (gv && g == i);
    rsv_ok = !(cnt_m[ra] == 3 && !(gv && ga == ra));
    inc = bus.rsv_valid && rsv_ok;
    if (!(inc && gv && ra == ga)) begin
      if (inc && cnt_m[ra] < 3) cnt_m[ra]++;
      if (gv) begin
        if (cnt_m[ga] > 0) cnt_m[ga]--;
        else               err_m = 1;
      end
    end
    we_m = gv;
    if (gv) begin
      waddr_m = ga;
      wdata_m = data_m[g];
      exp_q.push_back({ga, data_m[g]});
    end
    if (full_m[0] && full_m[1]) rr_m = !rr_m;
    for (int i = 0; i < 2; i++) begin
      if (bus.wb_valid[i] && rdy[i]) begin
        full_m[i] = 1;
        addr_m[i] = bus.wb_addr[i*4 +: 4];
        data_m[i] = bus.wb_data[i*16 +: 16];
      end else if (gv && g == i) begin
        full_m[i] = 0;
      end
    end
  endtask

  // Compare the registered outputs against the model.
  task automatic check_regs();
    logic [15:0] b;
    logic [19:0] front;
    for (int r = 0; r < NREGS; r++) b[r] = (cnt_m[r] != 0);
    chk("rf_we", bus.rf_we, we_m);
    chk("rf_waddr", bus.rf_waddr, waddr_m);
    chk("rf_wdata", bus.rf_wdata, wdata_m);
    chk("busy", bus.busy, b);
    chk("err_underflow", bus.err_underflow, err_m);
    if (bus.rf_we === 1'b1) begin
      chk("write_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        front = exp_q.pop_front();
        chk("write_order", {bus.rf_waddr, bus.rf_wdata}, front);
      end
    end
  endtask

  // One cycle with the inputs already driven: check readies, step model, check outputs.
  task automatic step();
    bit gv; int g; logic [1:0] er; bit ers;
    #1;
    model_grant(gv, g);
    er[0] = !full_m[0] || (gv && g == 0);
    er[1] = !full_m[1] || (gv && g == 1);
    chk("wb_ready", bus.wb_ready, er);
    if (bus.rsv_valid) begin
      ers = !(cnt_m[bus.rsv_addr] == 3 && !(gv && addr_m[g] == bus.rsv_addr));
      chk("rsv_ready", bus.rsv_ready, ers);
    end
    model_step();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // Driver tasks
  task automatic drive(input bit rv, input logic [3:0] ra, input logic [1:0] wv,
                       input logic [3:0] a0, input logic [15:0] d0,
                       input logic [3:0] a1, input logic [15:0] d1);
    bus.rsv_valid = rv;
    bus.rsv_addr  = ra;
    bus.wb_valid  = wv;
    bus.wb_addr   = {a1, a0};
    bus.wb_data   = {d1, d0};
  endtask

  task automatic idle();
    drive(0, 4'h0, 2'b00, 4'h0, 16'h0, 4'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_regs();
  endtask

  task automatic reserve(input logic [3:0] r);
    drive(1, r, 2'b00, 4'h0, 16'h0, 4'h0, 16'h0);
    step();
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_busy_lit", bus.busy, 16'h0000);
    chk("reset_we_lit", bus.rf_we, 1'b0);
    chk("reset_ready_lit", bus.wb_ready, 2'b11);

    // Single writeback to R3
    reserve(4'd3);
    chk("r3_busy_after_rsv_lit", bus.busy[3], 1'b1);
    drive(0, 4'h0, 2'b01, 4'd3, 16'h1234, 4'h0, 16'h0);
    step();
    idle();
    chk("r3_no_write_yet_lit", bus.rf_we, 1'b0);
    step();
    chk("r3_we_lit", bus.rf_we, 1'b1);
    chk("r3_waddr_lit", bus.rf_waddr, 4'd3);
    chk("r3_wdata_lit", bus.rf_wdata, 16'h1234);
    chk("r3_busy_clear_lit", bus.busy[3], 1'b0);

    // Two reservations of R3, two commits in order
    reserve(4'd3);
    reserve(4'd3);
    drive(0, 4'h0, 2'b01, 4'd3, 16'hAAAA, 4'h0, 16'h0);
    step();
    idle();
    step();
    chk("dbl_first_data_lit", bus.rf_wdata, 16'hAAAA);
    chk("dbl_still_busy_lit", bus.busy[3], 1'b1);
    drive(0, 4'h0, 2'b01, 4'd3, 16'hBBBB, 4'h0, 16'h0);
    step();
    idle();
    step();
    chk("dbl_second_data_lit", bus.rf_wdata, 16'hBBBB);
    chk("dbl_busy_clear_lit", bus.busy[3], 1'b0);

    // Contention, pointer at req0 then req1
    for (int rep = 0; rep < 2; rep++) begin
      reserve(4'd1);
      reserve(4'd2);
      drive(0, 4'h0, 2'b11, 4'd1, 16'h0001, 4'd2, 16'h0002);
      step();
      idle();
      #1;
      chk("cont_ready_lit", bus.wb_ready, (rep == 0) ? 2'b01 : 2'b10);
      step();
      chk("cont_first_lit", bus.rf_waddr, (rep == 0) ? 4'd1 : 4'd2);
      step();
      chk("cont_second_we_lit", bus.rf_we, 1'b1);
      chk("cont_second_lit", bus.rf_waddr, (rep == 0) ? 4'd2 : 4'd1);
      step();
    end

    // Saturation of R5
    reserve(4'd5);
    reserve(4'd5);
    reserve(4'd5);
    drive(1, 4'd5, 2'b00, 4'h0, 16'h0, 4'h0, 16'h0);
    #1;
    chk("sat_refused_lit", bus.rsv_ready, 1'b0);
    step();
    drive(0, 4'h0, 2'b01, 4'd5, 16'h0055, 4'h0, 16'h0);
    step();
    drive(1, 4'd5, 2'b00, 4'h0, 16'h0, 4'h0, 16'h0);
    #1;
    chk("sat_commit_frees_lit", bus.rsv_ready, 1'b1);
    step();
    chk("sat_busy_lit", bus.busy[5], 1'b1);
    #1;
    chk("sat_still_full_lit", bus.rsv_ready, 1'b0);
    idle();
    step();

    // Underflow on R7
    drive(0, 4'h0, 2'b01, 4'd7, 16'h0007, 4'h0, 16'h0);
    step();
    idle();
    step();
    chk("uf_we_lit", bus.rf_we, 1'b1);
    chk("uf_waddr_lit", bus.rf_waddr, 4'd7);
    chk("uf_err_lit", bus.err_underflow, 1'b1);
    chk("uf_busy_lit", bus.busy[7], 1'b0);
    step();
    chk("uf_err_sticky_lit", bus.err_underflow, 1'b1);

    // Reset with both buffers loaded
    drive(0, 4'h0, 2'b11, 4'd1, 16'h0101, 4'd2, 16'h0202);
    step();
    idle();
    do_reset();
    chk("rst_mid_we_lit", bus.rf_we, 1'b0);
    chk("rst_mid_busy_lit", bus.busy, 16'h0000);
    chk("rst_mid_err_lit", bus.err_underflow, 1'b0);
    chk("rst_mid_ready_lit", bus.wb_ready, 2'b11);
    step();
    chk("rst_mid_no_write_lit", bus.rf_we, 1'b0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)), 16'($urandom));
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)),
              {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0},
              4'($urandom_range(0, 15)), 16'($urandom),
              4'($urandom_range(0, 15)), 16'($urandom));
        step();
      end
    end
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 is the ALU/execute writeback, requester 1 is the load/memory writeback.
- Owns the register scoreboard as per-register pending-write counters, replacing single in-use bits, so two in-flight writes to the same register are tracked correctly.
- Sits between the execute/memory stages and the register file; the decode stage reserves destinations through it and reads its busy vector for hazard stalls.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register index width
- NREGS, 16, number of architectural registers (2**ADDR_W)
- CNT_W, 2, pending-write counter width per register (max 3 outstanding)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rsv_valid  in  1  decode requests reservation of rsv_addr
- rsv_addr  in  ADDR_W  destination register to reserve
- rsv_ready  out  1  reservation accepted this cycle (combinational)
- wb_valid  in  2  per-requester writeback valid
- wb_addr  in  2*ADDR_W  per-requester dest (req0 in low bits)
- wb_data  in  2*DATA_W  per-requester value (req0 in low bits)
- wb_ready  out  2  per-requester accept (combinational)
- rf_we  out  1  register-file write strobe, one cycle
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- busy  out  NREGS  busy[r] = pending count of r nonzero
- err_underflow  out  1  sticky: commit to a register with zero pending count

Behaviour:
- Reset (rst=1 at a clock edge):
  - all counters become 0 and both holding buffers empty
  - round-robin pointer set to requester 0
  - rf_we, rf_waddr, rf_wdata, busy and err_underflow become 0
  - reset mid-transfer discards buffered writebacks with no write issued
- Holding buffers: one entry per requester (addr + data + full flag).
  - wb_ready[i] = !full[i] || grant[i] in the current cycle
  - a handshake loads the buffer at the edge
- Arbitration: one grant per cycle among full buffers.
  - if both are full, the requester matching the rr pointer wins; the pointer then moves to the other requester
  - a single full buffer is granted without changing the pointer
- Output stage is registered. A granted entry drives rf_we=1 with its rf_waddr/rf_wdata on the next cycle.
  - rf_we is low on cycles with no grant; rf_waddr/rf_wdata hold their last values
- Latency: a writeback accepted at edge N with no contention is granted in cycle N and written (rf_we high) in cycle N+1. The worst case under contention is one extra cycle.
- Throughput: one write per cycle sustained. Each requester can stream back-to-back because a grant frees the buffer in the same cycle.
- Scoreboard, updated at each edge:
  - inc[r] = rsv_valid && rsv_ready && rsv_addr==r
  - dec[r] = grant && granted addr==r
  - both set on the same register: count unchanged
  - inc only: count +1
  - dec only with count>0: count -1
  - dec only with count==0: count stays 0 and err_underflow is set (sticky until rst)
- rsv_ready = !(count[rsv_addr]==max && !dec[rsv_addr]). At saturation decode stalls unless the same-cycle commit frees a slot.
- busy is registered from the counters, so it reflects state after the edge.
  - commit and release are visible the cycle after grant, aligned with rf_we
  - a reservation is visible the cycle after acceptance
- All registers, including index 0, are handled identically.
- X-safety: rsv_addr and wb_addr are ignored when their valid is low.

Decomposition:
- Shared package rf_pkg holds:
  - DATA_W, ADDR_W, NREGS, CNT_W constants
  - typedef wb_req_t {addr, data}
  - function for the round-robin next pointer
- One natural sub-module: rf_pend_counter, one saturating up/down counter with an underflow flag, instantiated NREGS times via generate.
- Arbiter and buffers stay in the top module.

Test Plan:
- Reset then a single writeback: rsv R3; next cycle wb_valid[0] with addr=3, data=0x1234.
  - Required: rf_we=1, waddr=3, wdata=0x1234 one cycle after acceptance.
  - busy[3] is 1 after rsv and 0 in the rf_we cycle.
- Same-register double reservation: rsv R3 twice, then commit R3 from req0.
  - busy[3] stays 1 after the first commit.
  - busy[3] clears only after the second commit (data 0xAAAA then 0xBBBB, written in that order).
- Contention: both buffers full in the same cycle (req0 R1 0x0001, req1 R2 0x0002), pointer at 0.
  - Required: R1 written in cycle N+1, R2 in N+2; wb_ready[1] low for one cycle.
  - Repeat: the pointer now favours req1.
- Saturation: rsv R5 three times, so count=3.
  - A fourth rsv gives rsv_ready=0.
  - A fourth rsv in the same cycle as a commit of R5 gives rsv_ready=1 and count stays 3.
- Underflow: commit R7 with no reservation.
  - Required: write still issued (rf_we=1, waddr=7), err_underflow=1 and held; busy[7]=0.
- Reset mid-operation: both buffers full, assert rst for one cycle.
  - Required: no rf_we afterwards, busy=0, err_underflow=0, wb_ready=2'b11.
